pc_seq: RTL
===========

Name: pc_seq

Overview:
- Parametrised program counter for the microcontroller controller; drives the ROM fetch address each cycle.
- Adds the following over the fixed 8-bit PC:
  - Configurable address width.
  - Multi-byte jump-target assembly from the data bus.
  - Condition-qualified jumps.
  - Hardware call/return stack of configurable depth.
  - Stall.
  - Sticky stack-error flag.

Parameters:
- DATA_WIDTH, 8, width of data bus and of one target byte.
- ADDR_WIDTH, 16, ROM address width. Must be a multiple of DATA_WIDTH.
- NBYTES, ADDR_WIDTH/DATA_WIDTH, bytes per target address (derived; not overridden).
- STACK_DEPTH, 4, return-stack entries (≥1).
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  1 = freeze all state this cycle
- load_byte  in  1  shift data_bus_in into target latch
- data_bus_in  in  DATA_WIDTH  target byte, MS byte first
- jump_req  in  1  conditional jump to latched target
- cond  in  1  jump condition; jump taken when cond==1
- call_req  in  1  push return address, jump to target
- ret_req  in  1  pop return address into PC
- rom_addr  out  ADDR_WIDTH  current PC
- target_ready  out  1  NBYTES bytes collected
- stack_empty  out  1  stack depth == 0
- stack_full  out  1  stack depth == STACK_DEPTH
- stack_err  out  1  sticky overflow/underflow

Behaviour:
- Reset (rst_n=0 at posedge):
  - PC = RESET_VECTOR; latch = 0; byte count = 0.
  - Stack depth = 0; stack_err = 0.
  - Outputs: rom_addr=RESET_VECTOR, target_ready=0, stack_empty=1, stack_full=0, stack_err=0.
  - Reset mid-assembly or with a non-empty stack discards everything.
- stall=1: PC, latch, count, stack and stack_err all hold. All request inputs are ignored that cycle.
- Collector FSM: COLLECT (count<NBYTES) / READY (count==NBYTES).
  - load_byte: latch <= {latch[ADDR_WIDTH-DATA_WIDTH-1:0], data_bus_in}; count saturates at NBYTES.
  - Extra bytes in READY keep shifting, so the last NBYTES bytes win.
  - target_ready = (count==NBYTES), registered.
  - Any jump_req, call_req or ret_req that is acted on (not stalled) clears count to 0 the same edge. The latch value is retained.
- PC update, one edge, priority ret_req > call_req > jump_req > sequential:
  - ret_req: if not empty, PC <= top, pop. If empty, PC <= PC+1 and stack_err <= 1.
  - call_req:
    - If target_ready and not full: push PC+1, PC <= latch.
    - If full: PC <= PC+1, stack_err <= 1, no push.
    - If not ready: PC <= PC+1, no push, no error.
  - jump_req: PC <= latch if target_ready && cond, else PC+1.
  - Otherwise: PC <= PC+1.
- A lower-priority request presented alongside a higher one is dropped, not queued. A load_byte in the same cycle is also dropped (count clear wins).
- load_byte alone does not stall the PC; PC still increments.
- Arithmetic: PC+1 is modulo 2^ADDR_WIDTH; max wraps to 0. A pushed return address wraps the same way.
- Stack: LIFO. Pop uses the top entry. stack_full/stack_empty are registered from depth. Push and pop never occur in the same cycle (priority rule).
- stack_err is cleared only by reset.
- Latency: request at edge N → rom_addr shows new value after edge N (one cycle).

Test Plan:
1. Reset then 5 free-running cycles → rom_addr 0,1,2,3,4,5; stack_empty=1; stack_err=0.
2. load_byte 0x12 then 0x34 → target_ready=1. Next cycle jump_req, cond=1 → rom_addr=0x1234, then 0x1235; target_ready=0. Repeat with cond=0 → PC+1.
3. Load 0xAA, 0x12, 0x34 → last two bytes kept; jump lands on 0x1234. jump_req after only one byte → PC+1, count cleared.
4. At PC=0x0010, load 0x0200, call → PC=0x0200, stack_empty=0. Later ret → PC=0x0011.
5. Five nested calls with depth 4 → stack_full=1. 5th call yields PC+1, stack_err=1. Four rets return in LIFO order. A 5th ret → PC+1, stack_err stays 1.
6. PC=0xFFFF → next 0x0000. stall=1 with jump_req → rom_addr holds. Reset asserted mid-assembly → rom_addr=RESET_VECTOR, target_ready=0.

Source files
------------

// File: rtl/pc_seq.sv
// Program counter with multi-byte target assembly, conditional jumps,
// a hardware call/return stack, stall and a sticky stack-error flag.
// rom_addr is the current PC and updates one edge after a request.
module pc_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  load_byte,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic                  jump_req,
    input  logic                  cond,
    input  logic                  call_req,
    input  logic                  ret_req,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  target_ready,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err
);

    // Bytes per target address; ADDR_WIDTH is expected to be a multiple of DATA_WIDTH.
    localparam int unsigned NBYTES  = ADDR_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(NBYTES + 1);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [CNT_W-1:0]   CntFull   = CNT_W'(NBYTES);
    localparam logic [DEPTH_W-1:0] DepthFull = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StReady   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d, pc_inc;
    logic [ADDR_WIDTH-1:0]   latch_q, latch_d, latch_shift;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic                    err_q, err_d;
    logic                    empty_q, full_q;
    logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic                    push_en;
    logic [PTR_W-1:0]        push_idx, top_idx;

    assign pc_inc = pc_q + ADDR_WIDTH'(1);
    // Shift form also covers NBYTES == 1, where the whole latch is replaced.
    assign latch_shift = (latch_q << DATA_WIDTH) | ADDR_WIDTH'(data_bus_in);
    assign push_idx    = PTR_W'(depth_q);
    assign top_idx     = PTR_W'(depth_q - DEPTH_W'(1));

    // Next-state: request priority ret > call > jump > load/sequential; stall freezes all.
    always_comb begin
        pc_d    = pc_q;
        latch_d = latch_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (!stall) begin
            pc_d = pc_inc;
            if (ret_req) begin
                cnt_d = '0;
                if (!empty_q) begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (call_req) begin
                cnt_d = '0;
                // A full stack is an error even if the target is not yet assembled.
                if (full_q) begin
                    err_d = 1'b1;
                end else if (state_q == StReady) begin
                    push_en = 1'b1;
                    pc_d    = latch_q;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end else if (jump_req) begin
                cnt_d = '0;
                if ((state_q == StReady) && cond) begin
                    pc_d = latch_q;
                end
            end else if (load_byte) begin
                latch_d = latch_shift;
                if (cnt_q != CntFull) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
        state_d = (cnt_d == CntFull) ? StReady : StCollect;
    end

    // State registers with synchronous active-low reset; stack storage needs no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StCollect;
            pc_q    <= RESET_VECTOR;
            latch_q <= '0;
            cnt_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            empty_q <= (depth_d == '0);
            full_q  <= (depth_d == DepthFull);
            if (push_en) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end

    assign rom_addr     = pc_q;
    assign target_ready = (state_q == StReady);
    assign stack_empty  = empty_q;
    assign stack_full   = full_q;
    assign stack_err    = err_q;

endmodule
